load_store_unit: RTL and testbench

- Initiator side of the data-memory interface.
- Accepts byte/halfword/word load and store requests from the CPU datapath.
- Drives the word-indexed data memory port: word address, write data, read strobe and write strobe. Read data is combinational; the memory writes on the clock's falling edge.
- Sub-word stores are done as read-modify-write. Load data is extracted, sign- or zero-extended, and returned with a one-cycle response pulse.

---
 rtl/load_store_unit_if.sv | 50 +++++
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for load_store_unit.
// The LSU_STATS_EN build adds the three statistics counters.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic [ADDR_W-1:0] reqAddr;
  logic [31:0]       reqWdata;
  logic              respValid;
  logic [31:0]       respRdata;
  logic              respError;
  logic [31:0]       memAddress;
  logic [31:0]       memWriteData;
  logic              memRead;
  logic              memWrite;
  logic [31:0]       memReadData;
`ifdef LSU_STATS_EN
  logic [31:0]       loadCount;
  logic [31:0]       storeCount;
  logic [31:0]       errCount;

  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, memReadData,
    input  reqReady, respValid, respRdata, respError,
           memAddress, memWriteData, memRead, memWrite,
           loadCount, storeCount, errCount
  );
  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, memReadData,
    output reqReady, respValid, respRdata, respError,
           memAddress, memWriteData, memRead, memWrite,
           loadCount, storeCount, errCount
  );
`else
  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, memReadData,
    input  reqReady, respValid, respRdata, respError,
           memAddress, memWriteData, memRead, memWrite
  );
  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, memReadData,
    output reqReady, respValid, respRdata, respError,
           memAddress, memWriteData, memRead, memWrite
  );
`endif
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-indexed data memory,
// sub-word stores via read-modify-write. Define LSU_STATS_EN for completion counters.
module load_store_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MISALIGN_CHECK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e      state_q,     state_d;
  logic        write_q,     write_d;
  logic [1:0]  size_q,      size_d;
  logic        signed_q,    signed_d;
  logic [1:0]  lane_q,      lane_d;
  logic [15:0] wdata_q,     wdata_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q,     rdata_d;
  logic        err_q,       err_d;

  logic [1:0]  lane_in;
  logic        misaligned;
  logic        req_err;

  // Extract the addressed lane from a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    extract = {{24{sg & b[7]}}, b};
      SZ_H:    extract = {{16{sg & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed byte/halfword lane of the old word.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                        input logic [1:0] sz, input logic [15:0] d);
    merge = w;
    if (sz == SZ_H) begin
      if (lane[1]) merge[31:16] = d;
      else         merge[15:0]  = d;
    end else begin
      case (lane)
        2'd0:    merge[7:0]   = d[7:0];
        2'd1:    merge[15:8]  = d[7:0];
        2'd2:    merge[23:16] = d[7:0];
        default: merge[31:24] = d[7:0];
      endcase
    end
  endfunction

  // Alignment classification; without checking, low bits are forced to alignment.
  always_comb begin
    lane_in    = bus.reqAddr[1:0];
    misaligned = ((bus.reqSize == SZ_H) && lane_in[0]) ||
                 ((bus.reqSize == SZ_W) && (lane_in != 2'b00));
    if (MISALIGN_CHECK == 0) begin
      if (bus.reqSize == SZ_H) lane_in[0] = 1'b0;
      if (bus.reqSize == SZ_W) lane_in    = 2'b00;
    end
    req_err = (bus.reqSize == 2'b11) || ((MISALIGN_CHECK != 0) && misaligned);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          write_d    = bus.reqWrite;
          size_d     = bus.reqSize;
          signed_d   = bus.reqSigned;
          lane_d     = lane_in;
          wdata_d    = bus.reqWdata[15:0];
          mem_addr_d = 32'(bus.reqAddr[ADDR_W-1:2]);
          if (req_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.reqWrite && (bus.reqSize == SZ_W)) begin
            mem_wdata_d = bus.reqWdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = merge(bus.memReadData, lane_q, size_q, wdata_q);
          state_d     = WRITE;
        end else begin
          rdata_d = extract(bus.memReadData, lane_q, size_q, signed_q);
          state_d = DONE;
        end
      end
      WRITE: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode the state register so reset drops them at once.
  assign bus.reqReady     = (state_q == IDLE);
  assign bus.memRead      = (state_q == READ);
  assign bus.memWrite     = (state_q == WRITE);
  assign bus.respValid    = (state_q == DONE);
  assign bus.respRdata    = rdata_q;
  assign bus.respError    = err_q;
  assign bus.memAddress   = mem_addr_q;
  assign bus.memWriteData = mem_wdata_q;

`ifdef LSU_STATS_EN
  logic [31:0] load_cnt_q, store_cnt_q, err_cnt_q;

  // Saturating completion counters, bumped at the end of DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (state_q == DONE) begin
      if (err_q) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
      end else if (write_q) begin
        if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_q <= store_cnt_q + 32'd1;
      end else begin
        if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_q <= load_cnt_q + 32'd1;
      end
    end
  end

  assign bus.loadCount  = load_cnt_q;
  assign bus.storeCount = store_cnt_q;
  assign bus.errCount   = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a falling-edge-write word memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();
  load_store_unit #(.ADDR_W(32), .MISALIGN_CHECK(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Word memory: combinational read, falling-edge write, plus a bench preload port.
  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  assign bus.memReadData = mem[bus.memAddress[5:0]];
  always @(negedge clk) begin
    if (poke_en)           mem[poke_idx] <= poke_val;
    else if (bus.memWrite) mem[bus.memAddress[5:0]] <= bus.memWriteData;
  end

  int checks = 0;
  int passes = 0;
  logic [32:0] exp_q[$];
  logic [32:0] act_q[$];

  always @(negedge clk) if (rst_n && bus.respValid) act_q.push_back({bus.respRdata, bus.respError});

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(posedge clk); poke_idx = idx; poke_val = val; poke_en = 1'b1;
    @(posedge clk); poke_en = 1'b0;
  endtask

  // Drive one request, push its expected response, and profile strobes until respValid.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       output int lat, output int rd, output int wr, output logic [31:0] waddr);
    int guard = 0;
    exp_q.push_back({er, ee});
    @(negedge clk);
    while (!bus.reqReady && guard < 20) begin @(negedge clk); guard++; end
    bus.reqValid = 1'b1; bus.reqWrite = w; bus.reqSize = sz; bus.reqSigned = sg;
    bus.reqAddr = a; bus.reqWdata = wd;
    @(posedge clk); #1;
    bus.reqValid = 1'b0; bus.reqWrite = 1'($urandom); bus.reqSize = 2'($urandom);
    bus.reqSigned = 1'($urandom); bus.reqAddr = $urandom; bus.reqWdata = $urandom;
    lat = 0; rd = 0; wr = 0; waddr = '0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (bus.memRead) rd++;
      if (bus.memWrite) begin wr++; waddr = bus.memAddress; end
      if (bus.respValid) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.reqReady !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.reqReady); else passes++;
    checks++;
    if ({bus.respValid, bus.respError, bus.memRead, bus.memWrite} !== 4'b0000)
      $display("FAIL reset_strobes got %b want 0000", {bus.respValid, bus.respError, bus.memRead, bus.memWrite});
    else passes++;
    checks++;
    if ({bus.respRdata, bus.memAddress, bus.memWriteData} !== 96'd0)
      $display("FAIL reset_data got %h want 0", {bus.respRdata, bus.memAddress, bus.memWriteData});
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [1:0]  sz [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    logic        sg [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [8] = '{32'h12, 32'h13, 32'h11, 32'h10, 32'h12, 32'h10, 32'h10, 32'h10};
    logic [31:0] ex [8] = '{32'hFFFFFF99, 32'h00000088, 32'hFFFFFFAA, 32'h000000BB,
                            32'hFFFF8899, 32'h0000AABB, 32'hFFFFAABB, 32'h8899AABB};
    int lat, rd, wr;
    logic [31:0] wa;
    logic [32:0] a, e;
    poke(6'd4, 32'h8899AABB);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'h0, ex[i], 1'b0, lat, rd, wr, wa);
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) $display("FAIL load%0d_resp got none want %h", i, e);
      else begin a = act_q.pop_front(); if (a !== e) $display("FAIL load%0d_resp got %h want %h", i, a, e); else passes++; end
      checks++;
      if ({lat, rd, wr} !== {32'd2, 32'd1, 32'd0})
        $display("FAIL load%0d_profile lat/rd/wr got %0d/%0d/%0d want 2/1/0", i, lat, rd, wr);
      else passes++;
      checks++;
      if ({bus.respValid, bus.respRdata} !== 33'd0)
        $display("FAIL load%0d_after got %b/%h want 0/0", i, bus.respValid, bus.respRdata);
      else passes++;
    end
  endtask

  task automatic test_store_word();
    int lat, rd, wr;
    logic [31:0] wa;
    logic [32:0] a, e;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, lat, rd, wr, wa);
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) $display("FAIL sw_resp got none want %h", e);
    else begin a = act_q.pop_front(); if (a !== e) $display("FAIL sw_resp got %h want %h", a, e); else passes++; end
    checks++;
    if ({lat, rd, wr, wa} !== {32'd2, 32'd0, 32'd1, 32'd8})
      $display("FAIL sw_profile lat/rd/wr/addr got %0d/%0d/%0d/%0d want 2/0/1/8", lat, rd, wr, wa);
    else passes++;
    checks++; if (mem[8] !== 32'hDEADBEEF) $display("FAIL sw_mem got %h want deadbeef", mem[8]); else passes++;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, lat, rd, wr, wa);
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) $display("FAIL sw_readback got none want %h", e);
    else begin a = act_q.pop_front(); if (a !== e) $display("FAIL sw_readback got %h want %h", a, e); else passes++; end
  endtask

  task automatic test_store_sub();
    logic [1:0]  sz [4] = '{2'b01, 2'b00, 2'b00, 2'b01};
    logic [31:0] ad [4] = '{32'h0E, 32'h0D, 32'h0C, 32'h0C};
    logic [31:0] wd [4] = '{32'h1234CAFE, 32'hFFFFFF55, 32'hABCDEF77, 32'h5555BEEF};
    logic [31:0] ex [4] = '{32'hCAFE3344, 32'hCAFE5544, 32'hCAFE5577, 32'hCAFEBEEF};
    int lat, rd, wr;
    logic [31:0] wa;
    logic [32:0] a, e;
    poke(6'd3, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, sz[i], 1'b1, ad[i], wd[i], 32'h0, 1'b0, lat, rd, wr, wa);
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) $display("FAIL rmw%0d_resp got none want %h", i, e);
      else begin a = act_q.pop_front(); if (a !== e) $display("FAIL rmw%0d_resp got %h want %h", i, a, e); else passes++; end
      checks++;
      if ({lat, rd, wr, wa} !== {32'd3, 32'd1, 32'd1, 32'd3})
        $display("FAIL rmw%0d_profile lat/rd/wr/addr got %0d/%0d/%0d/%0d want 3/1/1/3", i, lat, rd, wr, wa);
      else passes++;
      checks++; if (mem[3] !== ex[i]) $display("FAIL rmw%0d_mem got %h want %h", i, mem[3], ex[i]); else passes++;
    end
  endtask

  task automatic test_errors();
    logic        w  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sz [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [31:0] ad [5] = '{32'h05, 32'h22, 32'h21, 32'h10, 32'h0F};
    int lat, rd, wr;
    logic [31:0] wa;
    logic [32:0] a, e;
    for (int i = 0; i < 5; i++) begin
      issue(w[i], sz[i], 1'b0, ad[i], 32'h0BAD0BAD, 32'h0, 1'b1, lat, rd, wr, wa);
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) $display("FAIL err%0d_resp got none want %h", i, e);
      else begin a = act_q.pop_front(); if (a !== e) $display("FAIL err%0d_resp got %h want %h", i, a, e); else passes++; end
      checks++;
      if ({lat, rd, wr} !== {32'd1, 32'd0, 32'd0})
        $display("FAIL err%0d_profile lat/rd/wr got %0d/%0d/%0d want 1/0/0", i, lat, rd, wr);
      else passes++;
    end
    checks++;
    if ({mem[8], mem[3]} !== {32'hDEADBEEF, 32'hCAFEBEEF})
      $display("FAIL err_mem got %h/%h want deadbeef/cafebeef", mem[8], mem[3]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic ready_exp [3] = '{1'b0, 1'b0, 1'b1};
    logic [32:0] a, e;
    exp_q.push_back({32'h8899AABB, 1'b0});
    exp_q.push_back({32'h000000BE, 1'b0});
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'b10; bus.reqSigned = 1'b1; bus.reqAddr = 32'h10;
    @(posedge clk); #1;
    bus.reqSize = 2'b00; bus.reqSigned = 1'b0; bus.reqAddr = 32'h21;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.reqReady !== ready_exp[i]) $display("FAIL b2b_ready%0d got %b want %b", i, bus.reqReady, ready_exp[i]);
      else passes++;
    end
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) $display("FAIL b2b_resp%0d got none want %h", i, e);
      else begin a = act_q.pop_front(); if (a !== e) $display("FAIL b2b_resp%0d got %h want %h", i, a, e); else passes++; end
    end
  endtask

  task automatic test_reset_mid_write();
    poke(6'd16, 32'h01234567);
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'b00; bus.reqAddr = 32'h40; bus.reqWdata = 32'hAB;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.memWrite !== 1'b1) $display("FAIL rst_in_write got %b want 1", bus.memWrite); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.memWrite, bus.reqReady} !== 2'b01)
      $display("FAIL rst_drop write/ready got %b want 01", {bus.memWrite, bus.reqReady});
    else passes++;
    repeat (2) @(negedge clk);
    checks++; if (mem[16] !== 32'h01234567) $display("FAIL rst_mem got %h want 01234567", mem[16]); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.reqReady, bus.respValid, 32'(act_q.size())} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL rst_after ready/valid/resps got %b/%b/%0d want 1/0/0", bus.reqReady, bus.respValid, act_q.size());
    else passes++;
  endtask

`ifdef LSU_STATS_EN
  task automatic test_stats();
    logic        w  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  sz [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] ad [6] = '{32'h10, 32'h10, 32'h10, 32'h50, 32'h51, 32'h12};
    logic [31:0] ex [6] = '{32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h0, 32'h0, 32'h0};
    logic        ee [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, rd, wr;
    logic [31:0] wa;
    logic [32:0] a, e;
    checks++;
    if ({bus.loadCount, bus.storeCount, bus.errCount} !== 96'd0)
      $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", bus.loadCount, bus.storeCount, bus.errCount);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      issue(w[i], sz[i], 1'b0, ad[i], (i == 3) ? 32'h11111111 : 32'h22, ex[i], ee[i], lat, rd, wr, wa);
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) $display("FAIL stats%0d_resp got none want %h", i, e);
      else begin a = act_q.pop_front(); if (a !== e) $display("FAIL stats%0d_resp got %h want %h", i, a, e); else passes++; end
    end
    checks++; if (mem[20] !== 32'h11112211) $display("FAIL stats_mem got %h want 11112211", mem[20]); else passes++;
    checks++;
    if ({bus.loadCount, bus.storeCount, bus.errCount} !== {32'd3, 32'd2, 32'd1})
      $display("FAIL stats_counts got %0d/%0d/%0d want 3/2/1", bus.loadCount, bus.storeCount, bus.errCount);
    else passes++;
  endtask
`endif

  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'b00; bus.reqSigned = 1'b0;
    bus.reqAddr = '0; bus.reqWdata = '0;
    test_reset();
    test_loads();
    test_store_word();
    test_store_sub();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
`ifdef LSU_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
